// File: rtl/psram_pkg.sv
// Shared types and defaults for the PSRAM read arbiter slice.
package psram_pkg;

  localparam int ADDR_W        = 25;
  localparam int DATA_W        = 18;
  localparam int BURST_LEN_DEF = 4;
  localparam int TIMEOUT_DEF   = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/psram_rd_arb_if.sv
// AXI-style read address/data channel; used for the PSRAM port and for each requester.
interface psram_rd_arb_if;
  import psram_pkg::*;

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (output araddr, arvalid, input arready, rdata, rvalid);
  modport slave  (input araddr, arvalid, output arready, rdata, rvalid);

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer holds the last granted requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

  // Reset to "requester 1 last" so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               last_q <= 1'b1;
    else if (update && |req)    last_q <= gnt[1];
  end

endmodule

// File: rtl/psram_rd_arb.sv
// Arbitrates two read requesters onto one PSRAM burst port, one burst outstanding.
//   state  | meaning
//   S_IDLE | no burst; grant taken when psram_ready and a request is present
//   S_ADDR | arvalid driven with the granted address, waiting for arready
//   S_DATA | forwarding beats to the granted requester, watchdog running
module psram_rd_arb import psram_pkg::*; #(
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           psram_ready,
  psram_rd_arb_if.master mem,
  psram_rd_arb_if.slave  req0,
  psram_rd_arb_if.slave  req1,
  output logic           err_timeout
);

  localparam logic [3:0] BEAT_LAST = 4'(BURST_LEN - 1);
  localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic [3:0] beat_q, beat_d;
  logic [7:0] wd_q, wd_d;
  logic       err_d;
  logic       arb_en;
  logic [1:0] req_vec, gnt_oh;
  logic       in_addr, in_data;

  assign req_vec = {req1.arvalid, req0.arvalid};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_vec),
    .update  (arb_en),
    .gnt     (gnt_oh)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      beat_q      <= '0;
      wd_q        <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      beat_q      <= beat_d;
      wd_q        <= wd_d;
      err_timeout <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    wd_d    = wd_q;
    err_d   = 1'b0;
    arb_en  = 1'b0;
    if (!psram_ready) begin
      state_d = S_IDLE;
      beat_d  = '0;
      wd_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: if (|req_vec) begin
          arb_en  = 1'b1;
          grant_d = (gnt_oh == 2'b10);
          state_d = S_ADDR;
        end
        S_ADDR: if (mem.arready) begin
          state_d = S_DATA;
          beat_d  = '0;
          wd_d    = '0;
        end
        S_DATA: begin
          wd_d = wd_q + 8'd1;
          if (mem.rvalid) beat_d = beat_q + 4'd1;
          // A final beat landing on the watchdog limit still counts as a clean finish.
          if (mem.rvalid && beat_q == BEAT_LAST) begin
            state_d = S_IDLE;
            beat_d  = '0;
          end else if (wd_q == WD_LAST) begin
            state_d = S_IDLE;
            beat_d  = '0;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign in_addr = (state_q == S_ADDR);
  assign in_data = (state_q == S_DATA);

  assign mem.arvalid  = in_addr;
  assign mem.araddr   = in_addr ? (grant_q ? req1.araddr : req0.araddr) : '0;
  assign req0.arready = mem.arready & in_addr & ~grant_q;
  assign req1.arready = mem.arready & in_addr &  grant_q;
  assign req0.rvalid  = mem.rvalid & in_data & ~grant_q;
  assign req1.rvalid  = mem.rvalid & in_data &  grant_q;
  assign req0.rdata   = mem.rdata;
  assign req1.rdata   = mem.rdata;

endmodule

// File: tb/tb_psram_rd_arb.sv
// Directed bench for psram_rd_arb: single burst, round-robin, ready gating, watchdog, reset.
module tb_psram_rd_arb;
  import psram_pkg::*;

  logic clk;
  logic reset_n;
  logic psram_ready;
  logic err_timeout;
  int   tests;
  int   failed;

  psram_rd_arb_if mem_if ();
  psram_rd_arb_if r0_if ();
  psram_rd_arb_if r1_if ();

  psram_rd_arb dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .psram_ready (psram_ready),
    .mem         (mem_if.master),
    .req0        (r0_if.slave),
    .req1        (r1_if.slave),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    psram_ready    = 1'b1;
    mem_if.arready = 1'b0;
    mem_if.rvalid  = 1'b0;
    mem_if.rdata   = '0;
    r0_if.arvalid  = 1'b0;
    r0_if.araddr   = '0;
    r1_if.arvalid  = 1'b0;
    r1_if.araddr   = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // One full burst of 4 back-to-back beats; expects the given winner and address.
  task automatic run_burst(input string tag, input int exp_g, input logic [24:0] exp_addr);
    int  n0, n1, waits;
    bit  seen;
    n0 = 0; n1 = 0; waits = 0; seen = 0;
    while (!seen && waits < 6) begin
      #1;
      if (mem_if.arvalid) seen = 1;
      else begin tick(); waits++; end
    end
    chk({tag, "_arvalid_seen"}, 32'(seen), 32'd1);
    chk({tag, "_araddr"}, 32'(mem_if.araddr), 32'(exp_addr));
    mem_if.arready = 1'b1;
    #1;
    chk({tag, "_r0_arready"}, 32'(r0_if.arready), 32'(exp_g == 0));
    chk({tag, "_r1_arready"}, 32'(r1_if.arready), 32'(exp_g == 1));
    tick();
    mem_if.arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_if.rvalid = 1'b1;
      mem_if.rdata  = 18'(i + 16);
      #1;
      n0 += int'(r0_if.rvalid);
      n1 += int'(r1_if.rvalid);
      tick();
    end
    mem_if.rvalid = 1'b0;
    chk({tag, "_beats_granted"}, 32'(exp_g == 0 ? n0 : n1), 32'd4);
    chk({tag, "_beats_other"}, 32'(exp_g == 0 ? n1 : n0), 32'd0);
  endtask

  initial begin
    int n0, n1, pulses, pulse_at;
    logic [7:0] pat;
    tests = 0;
    failed = 0;
    reset_n = 1'b0;
    clear_inputs();

    // Reset state with live-looking inputs present
    r0_if.arvalid  = 1'b1;
    mem_if.arready = 1'b1;
    mem_if.rvalid  = 1'b1;
    tick();
    tick();
    chk("rst_arvalid", 32'(mem_if.arvalid), 32'd0);
    chk("rst_araddr", 32'(mem_if.araddr), 32'd0);
    chk("rst_r0_arready", 32'(r0_if.arready), 32'd0);
    chk("rst_r0_rvalid", 32'(r0_if.rvalid), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    clear_inputs();
    reset_n = 1'b1;
    tick();

    // Req0 alone, arready on 2nd arvalid cycle, 4 beats with gaps plus a stray beat
    r0_if.arvalid = 1'b1;
    r0_if.araddr  = 25'h000008;
    #1;
    chk("t1_latency_arvalid0", 32'(mem_if.arvalid), 32'd0);
    tick();
    chk("t1_arvalid", 32'(mem_if.arvalid), 32'd1);
    chk("t1_araddr", 32'(mem_if.araddr), 32'h8);
    chk("t1_r0_arready_wait", 32'(r0_if.arready), 32'd0);
    tick();
    mem_if.arready = 1'b1;
    #1;
    chk("t1_r0_arready", 32'(r0_if.arready), 32'd1);
    chk("t1_r1_arready", 32'(r1_if.arready), 32'd0);
    tick();
    mem_if.arready = 1'b0;
    r0_if.arvalid  = 1'b0;
    pat = 8'b0110_1101;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      mem_if.rvalid = pat[i];
      mem_if.rdata  = 18'h2A000 + 18'(i);
      #1;
      n0 += int'(r0_if.rvalid);
      n1 += int'(r1_if.rvalid);
      if (i == 2) chk("t1_rdata_bcast", 32'(r1_if.rdata), 32'h2A002);
      tick();
    end
    mem_if.rvalid = 1'b0;
    chk("t1_r0_beats", 32'(n0), 32'd4);
    chk("t1_r1_beats", 32'(n1), 32'd0);
    chk("t1_idle", 32'(dut.state_q), 32'(S_IDLE));

    // Both requesting continuously from a fresh reset: 0,1,0,1
    clear_inputs();
    do_reset();
    r0_if.arvalid = 1'b1;
    r0_if.araddr  = 25'h0000100;
    r1_if.arvalid = 1'b1;
    r1_if.araddr  = 25'h0000200;
    run_burst("t2_b0", 0, 25'h100);
    run_burst("t2_b1", 1, 25'h200);
    run_burst("t2_b2", 0, 25'h100);
    run_burst("t2_b3", 1, 25'h200);
    r0_if.arvalid = 1'b0;
    r1_if.arvalid = 1'b0;
    tick();

    // psram_ready gating, then abort in S_ADDR
    psram_ready   = 1'b0;
    r0_if.arvalid = 1'b1;
    r0_if.araddr  = 25'h0000033;
    n0 = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n0 += int'(mem_if.arvalid);
      tick();
    end
    chk("t3_not_ready_arvalid", 32'(n0), 32'd0);
    psram_ready = 1'b1;
    #1;
    chk("t3_rise_arvalid0", 32'(mem_if.arvalid), 32'd0);
    tick();
    chk("t3_rise_arvalid1", 32'(mem_if.arvalid), 32'd1);
    chk("t3_araddr", 32'(mem_if.araddr), 32'h33);
    psram_ready   = 1'b0;
    r0_if.arvalid = 1'b0;
    tick();
    chk("t3_abort_arvalid", 32'(mem_if.arvalid), 32'd0);
    chk("t3_abort_idle", 32'(dut.state_q), 32'(S_IDLE));
    psram_ready = 1'b1;
    tick();

    // Watchdog: req1 granted, 2 beats then silence, stray beats after abort
    r1_if.arvalid = 1'b1;
    r1_if.araddr  = 25'h1ABCDEF;
    tick();
    chk("t4_araddr", 32'(mem_if.araddr), 32'h1ABCDEF);
    mem_if.arready = 1'b1;
    #1;
    chk("t4_r1_arready", 32'(r1_if.arready), 32'd1);
    tick();
    mem_if.arready = 1'b0;
    r1_if.arvalid  = 1'b0;
    n1 = 0; pulses = 0; pulse_at = -1;
    for (int k = 0; k < 260; k++) begin
      mem_if.rvalid = (k < 2) || (k >= 256);
      #1;
      n1 += int'(r1_if.rvalid);
      if (err_timeout) begin
        pulses++;
        pulse_at = k;
      end
      tick();
    end
    mem_if.rvalid = 1'b0;
    chk("t4_err_pulses", 32'(pulses), 32'd1);
    chk("t4_err_cycle", 32'(pulse_at), 32'd255);
    chk("t4_r1_beats", 32'(n1), 32'd2);
    chk("t4_idle", 32'(dut.state_q), 32'(S_IDLE));

    // Reset during beat 2; pointer would favour req1 without the reset
    r0_if.arvalid = 1'b1;
    r0_if.araddr  = 25'h0000044;
    tick();
    mem_if.arready = 1'b1;
    tick();
    mem_if.arready = 1'b0;
    r0_if.arvalid  = 1'b0;
    mem_if.rvalid  = 1'b1;
    tick();
    #1;
    chk("t5_beat2_fwd", 32'(r0_if.rvalid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_rvalid", 32'(r0_if.rvalid), 32'd0);
    chk("t5_rst_arvalid", 32'(mem_if.arvalid), 32'd0);
    chk("t5_rst_araddr", 32'(mem_if.araddr), 32'd0);
    chk("t5_rst_err", 32'(err_timeout), 32'd0);
    chk("t5_rst_idle", 32'(dut.state_q), 32'(S_IDLE));
    tick();
    mem_if.rvalid = 1'b0;
    reset_n = 1'b1;
    r0_if.arvalid = 1'b1;
    r0_if.araddr  = 25'h0000010;
    r1_if.arvalid = 1'b1;
    r1_if.araddr  = 25'h0000020;
    run_burst("t5_tie", 0, 25'h10);
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
